// File: rtl/chan_resp_checker_if.sv
// chan_resp_checker_if: request/ack/done monitor bus with sticky error reporting
interface chan_resp_checker_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  ack;
   logic             done;
   logic             clr_err;
   logic [N_CH-1:0]  busy;
   logic [N_CH-1:0]  err_timeout;
   logic [N_CH-1:0]  err_done;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   modport master (
      output en, req, ack, done, clr_err,
      input  busy, err_timeout, err_done, err_pulse, err_count
   );
   modport slave (
      input  en, req, ack, done, clr_err,
      output busy, err_timeout, err_done, err_pulse, err_count
   );
endinterface

// File: rtl/chan_resp_checker.sv
// chan_resp_checker: per-channel req -> ack within MAX_LAT -> done next cycle protocol checker
module chan_resp_checker #(
   parameter int N_CH    = 4,
   parameter int MAX_LAT = 4,
   parameter int CNT_W   = 8
) (
   input logic clk,
   input logic rst,
   chan_resp_checker_if.slave s
);
   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
   localparam logic [7:0] LAT = 8'(MAX_LAT);
   localparam logic [CNT_W+5:0] SAT = {6'd0, {CNT_W{1'b1}}};
   logic [N_CH-1:0] to_v, dn_v, bsy;
   logic [CNT_W+5:0] sum;
   logic [CNT_W-1:0] base;
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t st;
      logic [7:0] cnt;
      logic b;
      always_ff @(posedge clk)
         if (rst) begin
            st  <= IDLE;
            cnt <= 8'd0;
            b   <= 1'b0;
         end else
            case (st)
               IDLE: if (s.en && s.req[i]) begin
                  st  <= WAIT_ACK;
                  cnt <= 8'd1;
                  b   <= 1'b1;
               end
               WAIT_ACK: if (s.ack[i]) st <= WAIT_DONE;
               else if (cnt == LAT) begin
                  st <= IDLE;
                  b  <= 1'b0;
               end else cnt <= cnt + 8'd1;
               default: begin
                  st <= IDLE;
                  b  <= 1'b0;
               end
            endcase
      assign bsy[i]  = b;
      assign to_v[i] = st == WAIT_ACK && !s.ack[i] && cnt == LAT;
      assign dn_v[i] = st == WAIT_DONE && !s.done;
   end
   assign s.busy = bsy;
   // a violation coinciding with clr_err survives the clear
   always_comb begin
      base = s.clr_err ? '0 : s.err_count;
      sum  = {6'd0, base} + (CNT_W+6)'($countones(to_v)) + (CNT_W+6)'($countones(dn_v));
   end
   always_ff @(posedge clk)
      if (rst) begin
         s.err_timeout <= '0;
         s.err_done    <= '0;
         s.err_pulse   <= 1'b0;
         s.err_count   <= '0;
      end else begin
         s.err_timeout <= (s.clr_err ? '0 : s.err_timeout) | to_v;
         s.err_done    <= (s.clr_err ? '0 : s.err_done) | dn_v;
         s.err_pulse   <= |(to_v | dn_v);
         s.err_count   <= sum > SAT ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
endmodule

// File: doc/chan_resp_checker.md
CHAN_RESP_CHECKER -- requirements
Module: chan_resp_checker

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent monitored channels (1..32).
REQ-002 The block SHALL have parameter MAX_LAT, default 4, giving the maximum req-to-ack latency in cycles (1..255).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  activation condition; new transactions start only while en=1.
REQ-007 req  input  N_CH  per-channel request strobe.
REQ-008 ack  input  N_CH  per-channel acknowledge.
REQ-009 done  input  1  shared completion signal, required high one cycle after an ack.
REQ-010 clr_err  input  1  clears sticky error flags and the error counter.
REQ-011 busy  output  N_CH  channel has an outstanding transaction.
REQ-012 err_timeout  output  N_CH  sticky flag: ack missed its window.
REQ-013 err_done  output  N_CH  sticky flag: done low in the cycle after ack.
REQ-014 err_pulse  output  1  one-cycle pulse for any new violation.
REQ-015 err_count  output  CNT_W  saturating count of violations.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, WAIT_ACK and WAIT_DONE.
REQ-017 IDLE -> WAIT_ACK when en=1 and req[i]=1 in cycle t, with the latency counter loaded to 1.
REQ-018 In WAIT_ACK, ack[i]=1 in any of cycles t+1..t+MAX_LAT SHALL move the channel to WAIT_DONE.
REQ-019 In WAIT_ACK, no ack[i] by cycle t+MAX_LAT SHALL be a timeout violation in that cycle; the channel then returns to IDLE.
REQ-020 In WAIT_DONE (cycle a+1 after ack at cycle a), done=1 SHALL be a pass and done=0 a done violation; either way the channel returns to IDLE.
REQ-021 MAX_LAT=1 SHALL reduce the check to req |=> ack ##1 done.
REQ-022 req[i] while busy[i]=1 SHALL be ignored: no new transaction and no violation. req[i] in the cycle a channel returns to IDLE SHALL also be ignored.
REQ-023 ack[i] in IDLE or WAIT_DONE SHALL be ignored.
REQ-024 en deasserting mid-transaction SHALL NOT abort it; the transaction completes and is checked normally.
REQ-025 busy[i] SHALL be 1 exactly while channel i is in WAIT_ACK or WAIT_DONE.
REQ-026 All outputs SHALL be registered; a violation in cycle v is visible from cycle v+1.
REQ-027 A violation SHALL set the matching sticky flag and assert err_pulse for exactly cycle v+1.
REQ-028 err_count SHALL add the number of channels violating in cycle v (popcount, 0..N_CH), saturating at 2^CNT_W-1 without wrapping.
REQ-029 clr_err=1 SHALL zero err_timeout, err_done and err_count. A violation in the same cycle SHALL win: after the clear, its flag is set and err_count equals that cycle's popcount.
REQ-030 clr_err SHALL NOT affect FSM state or busy.

Reset
REQ-031 rst=1 at a clock edge SHALL return every FSM to IDLE and zero every output, including busy, the sticky flags, err_pulse and err_count.
REQ-032 rst SHALL take priority over all inputs; a transaction in flight at reset SHALL be discarded with no violation reported.

Verification
REQ-033 Pass: en=1, req[0]=1 at t, ack[0]=1 at t+2, done=1 at t+3 -> busy[0] high t+1..t+3, no error flags, err_count=0.
REQ-034 Timeout: req[1]=1 at t, no ack -> err_timeout[1]=1 and err_pulse=1 at t+5; busy[1] low at t+5.
REQ-035 Simultaneous violations: channels 0, 2 and 3 each ack followed by done=0 in the same cycle v -> err_done=4'b1101 and err_count=3 at v+1; err_pulse=1 for one cycle only.
REQ-036 Saturation and clear: CNT_W=2, five single violations -> err_count holds 3; clr_err together with a new violation -> err_count=1 and that flag set.
REQ-037 Gating and reset: req[0] with en=0 -> no transaction. req[0] with en=1, then en=0 at t+1 -> transaction still checked. rst at t+1 during WAIT_ACK -> all outputs 0 and no later timeout.
